// File: rtl/snake_engine.sv
// snake_engine: snake game FSM, body store, direction filter and LFSR food placement on the 16x16 grid.
module snake_engine #(
  parameter logic [3:0] INIT_LENGTH = 4'd3,
  parameter logic [3:0] WIN_LENGTH  = 4'd15,
  parameter logic [7:0] START_LOC   = 8'h77,
  parameter logic [7:0] FOOD_INIT   = 8'h7B,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Start,
  input  logic         Ack,
  input  logic         Tick,
  input  logic         BtnU,
  input  logic         BtnD,
  input  logic         BtnL,
  input  logic         BtnR,
  output logic [127:0] Locations_Flat,
  output logic [3:0]   Length,
  output logic [7:0]   Food,
  output logic         Qi,
  output logic         Qc,
  output logic         Ql,
  output logic         Qw
);
  typedef enum logic [2:0] {S_INIT, S_PLAY, S_FOOD, S_LOSE, S_WIN} state_t;
  localparam logic [1:0] D_U = 2'd0, D_D = 2'd1, D_L = 2'd2, D_R = 2'd3;
  state_t state, state_d;
  logic [7:0] loc [16];
  logic [1:0] dir_cur, dir_next, btn_dir, dir_eff;
  logic [7:0] lfsr, nh;
  logic [3:0] row, col, len_inc, flags_d;
  logic [4:0] lim;
  logic tick_pend, btn_ok, move, wall, eat, self_hit, food_hit, food_ok, die, load;
  assign row = loc[0][7:4];
  assign col = loc[0][3:0];
  for (genvar k = 0; k < 16; k++) assign Locations_Flat[127-8*k -: 8] = loc[k];
  // Directions are paired so that a reversal is always dir ^ 1.
  always_comb begin
    btn_dir = BtnU ? D_U : BtnD ? D_D : BtnL ? D_L : D_R;
    btn_ok = (BtnU | BtnD | BtnL | BtnR) && btn_dir != (dir_cur ^ 2'd1) && (state == S_PLAY || state == S_FOOD);
    dir_eff = btn_ok ? btn_dir : dir_next;
    nh = dir_eff == D_U ? {row - 4'd1, col} : dir_eff == D_D ? {row + 4'd1, col} :
         dir_eff == D_L ? {row, col - 4'd1} : {row, col + 4'd1};
    wall = dir_eff == D_U ? row == 4'h0 : dir_eff == D_D ? row == 4'hF :
           dir_eff == D_L ? col == 4'h0 : col == 4'hF;
    eat = nh == Food;
    lim = {1'b0, Length} - {4'd0, !eat};
    self_hit = 1'b0;
    food_hit = 1'b0;
    for (int i = 0; i < 16; i++) begin
      self_hit |= loc[i] == nh && 5'(i) < lim;
      food_hit |= loc[i] == lfsr && 5'(i) < {1'b0, Length};
    end
    die = wall | self_hit;
    move = state == S_PLAY && (Tick || tick_pend);
    len_inc = Length + 4'd1;
    food_ok = !food_hit && lfsr != 8'h00;
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state <= S_INIT;
      {Qi, Qc, Ql, Qw} <= 4'b1000;
    end else begin
      state <= state_d;
      {Qi, Qc, Ql, Qw} <= flags_d;
    end
  always_comb begin
    state_d = state;
    case (state)
      S_INIT:  state_d = Start ? S_PLAY : S_INIT;
      S_PLAY:  state_d = !move ? S_PLAY : die ? S_LOSE : !eat ? S_PLAY : len_inc == WIN_LENGTH ? S_WIN : S_FOOD;
      S_FOOD:  state_d = food_ok ? S_PLAY : S_FOOD;
      default: state_d = Ack ? S_INIT : state;
    endcase
  end
  always_comb begin
    flags_d = {state_d == S_INIT, state_d == S_PLAY || state_d == S_FOOD, state_d == S_LOSE, state_d == S_WIN};
    load = state == S_INIT || state_d == S_INIT;
  end
  // Init values are reloaded on every INIT cycle, including the Ack edge that enters it.
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      for (int i = 0; i < 16; i++) loc[i] <= 4'(i) < INIT_LENGTH ? START_LOC - 8'(i) : 8'h00;
      Length <= INIT_LENGTH;
      Food <= FOOD_INIT;
      dir_cur <= D_R;
      dir_next <= D_R;
      lfsr <= LFSR_SEED;
      tick_pend <= 1'b0;
    end else if (load) begin
      for (int i = 0; i < 16; i++) loc[i] <= 4'(i) < INIT_LENGTH ? START_LOC - 8'(i) : 8'h00;
      Length <= INIT_LENGTH;
      Food <= FOOD_INIT;
      dir_cur <= D_R;
      dir_next <= D_R;
      lfsr <= LFSR_SEED;
      tick_pend <= 1'b0;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (btn_ok) dir_next <= btn_dir;
      if (state == S_PLAY) tick_pend <= 1'b0;
      else if (state == S_FOOD && Tick) tick_pend <= 1'b1;
      if (move && !die) begin
        for (int i = 15; i > 0; i--) loc[i] <= loc[i-1];
        loc[0] <= nh;
        dir_cur <= dir_eff;
        dir_next <= dir_eff;
        if (eat) Length <= len_inc;
      end
      if (state == S_FOOD && food_ok) Food <= lfsr;
    end
endmodule

// File: tb/tb_snake_engine.sv
// tb_snake_engine: scoreboard bench for snake_engine; a second instance with WIN_LENGTH=5 shares the stimulus.
module tb_snake_engine;
  logic Clk = 1'b0, Reset_n = 1'b0;
  logic Start = 1'b0, Ack = 1'b0, Tick = 1'b0, BtnU = 1'b0, BtnD = 1'b0, BtnL = 1'b0, BtnR = 1'b0;
  logic [127:0] loc_a, loc_w;
  logic [3:0] len_a, len_w;
  logic [7:0] food_a, food_w;
  logic qi_a, qc_a, ql_a, qw_a, qi_w, qc_w, ql_w, qw_w;
  localparam logic [3:0] QI = 4'b1000, QC = 4'b0100, QL = 4'b0010, QW = 4'b0001;
  localparam logic [6:0] N = 7'd0, ST = 7'b1000000, AK = 7'b0100000, TK = 7'b0010000;
  localparam logic [6:0] BU = 7'b0001000, BD = 7'b0000100, BL = 7'b0000010, BR = 7'b0000001;
  localparam logic [127:0] INIT_LOC = {24'h777675, 104'h0};
  snake_engine dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Ack(Ack), .Tick(Tick),
    .BtnU(BtnU), .BtnD(BtnD), .BtnL(BtnL), .BtnR(BtnR),
    .Locations_Flat(loc_a), .Length(len_a), .Food(food_a),
    .Qi(qi_a), .Qc(qc_a), .Ql(ql_a), .Qw(qw_a)
  );
  snake_engine #(.WIN_LENGTH(4'd5)) dut_w (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Ack(Ack), .Tick(Tick),
    .BtnU(BtnU), .BtnD(BtnD), .BtnL(BtnL), .BtnR(BtnR),
    .Locations_Flat(loc_w), .Length(len_w), .Food(food_w),
    .Qi(qi_w), .Qc(qc_w), .Ql(ql_w), .Qw(qw_w)
  );
  always #5 Clk = ~Clk;
  typedef struct {
    string tag;
    logic [3:0] q;
    logic [3:0] len;
    logic [7:0] head;
    logic [7:0] food;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int n_cmp = 0, n_bad = 0;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  always @(posedge Clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check($sformatf("%s.q", mon_e.tag), {qi_a, qc_a, ql_a, qw_a}, mon_e.q);
      check($sformatf("%s.len", mon_e.tag), len_a, mon_e.len);
      check($sformatf("%s.head", mon_e.tag), loc_a[127:120], mon_e.head);
      check($sformatf("%s.food", mon_e.tag), food_a, mon_e.food);
    end
  end
  task automatic step(input string tag, input logic [6:0] in, input logic [3:0] q, input logic [3:0] len,
                      input logic [7:0] head, input logic [7:0] food);
    exp_t e;
    {Start, Ack, Tick, BtnU, BtnD, BtnL, BtnR} = in;
    e.tag = tag;
    e.q = q;
    e.len = len;
    e.head = head;
    e.food = food;
    sb.push_back(e);
    @(posedge Clk);
    #2;
    {Start, Ack, Tick, BtnU, BtnD, BtnL, BtnR} = N;
  endtask
  initial begin
    logic hit;
    repeat (2) @(posedge Clk);
    #2;
    Reset_n = 1'b1;
    check("rst_q", {qi_a, qc_a, ql_a, qw_a}, QI);
    check("rst_len", len_a, 4'd3);
    check("rst_loc", loc_a, INIT_LOC);
    check("rst_food", food_a, 8'h7B);
    step("init_ign", TK | BU, QI, 3, 8'h77, 8'h7B);
    step("start", ST, QC, 3, 8'h77, 8'h7B);
    step("t1", TK, QC, 3, 8'h78, 8'h7B);
    step("t2", TK, QC, 3, 8'h79, 8'h7B);
    step("t3", TK, QC, 3, 8'h7A, 8'h7B);
    step("t4_eat", TK, QC, 4, 8'h7B, 8'h7B);
    check("body_eat", loc_a[127:96], 32'h7B7A7978);
    step("food_tick", TK, QC, 4, 8'h7B, 8'h54);
    step("pend_move", N, QC, 4, 8'h7C, 8'h54);
    check("body_pend", loc_a[127:96], 32'h7C7B7A79);
    hit = 1'b0;
    for (int i = 0; i < 4; i++) if (loc_a[127-8*i -: 8] == food_a) hit = 1'b1;
    check("food_free", {food_a != 8'h00, hit}, 2'b10);
    step("rev_l", BL, QC, 4, 8'h7C, 8'h54);
    step("rev_t", TK, QC, 4, 8'h7D, 8'h54);
    step("lp4_u", TK | BU, QC, 4, 8'h6D, 8'h54);
    step("lp4_l", TK | BL, QC, 4, 8'h6C, 8'h54);
    step("lp4_d", TK | BD, QC, 4, 8'h7C, 8'h54);
    step("lp4_r", TK | BR, QC, 4, 8'h7D, 8'h54);
    check("lp4_body", loc_a[127:96], 32'h7D7C6C6D);
    step("prio_ur", TK | BU | BR, QC, 4, 8'h6D, 8'h54);
    step("ack_play", AK, QC, 4, 8'h6D, 8'h54);
    check("w_track", {qc_w, len_w, loc_w[127:120]}, {1'b1, 4'd4, 8'h6D});
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    check("mid_rst_q", {qi_a, qc_a, ql_a, qw_a}, QI);
    check("mid_rst_st", {len_a, food_a, loc_a}, {4'd3, 8'h7B, INIT_LOC});
    check("mid_rst_w", {qi_w, len_w}, {1'b1, 4'd3});
    @(posedge Clk);
    #2;
    Reset_n = 1'b1;
    step("b_start", ST, QC, 3, 8'h77, 8'h7B);
    step("b_btnu", BU, QC, 3, 8'h77, 8'h7B);
    for (int i = 1; i <= 7; i++) step("b_up", TK, QC, 3, {4'(7 - i), 4'h7}, 8'h7B);
    step("b_wall", TK, QL, 3, 8'h07, 8'h7B);
    check("b_frozen", loc_a[127:104], 24'h071727);
    step("b_lose_tick", TK | BD, QL, 3, 8'h07, 8'h7B);
    step("b_lose_start", ST, QL, 3, 8'h07, 8'h7B);
    check("w_lose", {qi_w, qc_w, ql_w, qw_w}, QL);
    step("b_ack", AK, QI, 3, 8'h77, 8'h7B);
    check("b_reload", loc_a, INIT_LOC);
    check("w_reload", loc_w, INIT_LOC);
    step("c_start", ST, QC, 3, 8'h77, 8'h7B);
    step("c_t1", TK, QC, 3, 8'h78, 8'h7B);
    step("c_t2", TK, QC, 3, 8'h79, 8'h7B);
    step("c_t3", TK, QC, 3, 8'h7A, 8'h7B);
    step("c_t4", TK, QC, 4, 8'h7B, 8'h7B);
    step("c_food", N, QC, 4, 8'h7B, 8'h54);
    step("c_u", TK | BU, QC, 4, 8'h6B, 8'h54);
    step("c_l", TK | BL, QC, 4, 8'h6A, 8'h54);
    for (int i = 1; i <= 8; i++) step("c_left", TK, QC, 4, 8'h6A - 8'(i), 8'h54);
    step("c_u2", TK | BU, QC, 4, 8'h52, 8'h54);
    step("c_r", TK | BR, QC, 4, 8'h53, 8'h54);
    step("c_eat", TK, QC, 5, 8'h54, 8'h54);
    check("w_win", {qi_w, qc_w, ql_w, qw_w}, QW);
    check("w_len", len_w, 4'd5);
    check("w_body", loc_w[127:88], 40'h5453526263);
    step("c_food2", N, QC, 5, 8'h54, 8'hB3);
    check("c_body5", loc_a[127:88], 40'h5453526263);
    step("c5_u", TK | BU, QC, 5, 8'h44, 8'hB3);
    step("c5_l", TK | BL, QC, 5, 8'h43, 8'hB3);
    step("c5_d", TK | BD, QL, 5, 8'h43, 8'hB3);
    check("c5_frozen", loc_a[127:88], 40'h4344545352);
    check("w_hold", {qi_w, qc_w, ql_w, qw_w, len_w, loc_w[127:88], food_w}, {QW, 4'd5, 40'h5453526263, 8'h54});
    step("c_ack", AK, QI, 3, 8'h77, 8'h7B);
    check("w_ack", {qi_w, qc_w, ql_w, qw_w, len_w, food_w}, {QI, 4'd3, 8'h7B});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
